// File: rtl/word_stack_shiftreg.sv
// word_stack_shiftreg: DEPTH x WIDTH operand stack as a word-wide shift chain, entry 0 = top.
// Define WSTACK_ROT_EN to make opcode 111 a ROT of the top three entries; otherwise 111 is a NOP.
module word_stack_shiftreg #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] second,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf,
    output logic             err
);
    localparam logic [2:0] OP_PUSH = 3'd1, OP_POP = 3'd2, OP_DUP = 3'd3, OP_SWAP = 3'd4,
                           OP_OVER = 3'd5, OP_REPL = 3'd6, OP_ROT = 3'd7;

    logic [WIDTH-1:0] s   [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [CW-1:0]    nc;
    logic             need1, need2, need3, pushes, unf_c, ovf_c, ok;
    logic [WIDTH-1:0] pv;

    assign need1  = op == OP_POP || op == OP_DUP || op == OP_REPL;
    assign need2  = op == OP_SWAP || op == OP_OVER;
`ifdef WSTACK_ROT_EN
    assign need3  = op == OP_ROT;
`else
    assign need3  = 1'b0;
`endif
    assign pushes = op == OP_PUSH || op == OP_DUP || op == OP_OVER;
    // Operand shortage is reported in preference to lack of space.
    assign unf_c  = en && ((need1 && count == '0) || (need2 && count < CW'(2)) ||
                           (need3 && count < CW'(3)));
    assign ovf_c  = en && !unf_c && pushes && count == CW'(DEPTH);
    assign ok     = en && !unf_c && !ovf_c;
    assign pv     = op == OP_PUSH ? d : op == OP_DUP ? s[0] : s[1];

    always_comb begin
        nxt = s;
        nc  = count;
        if (ok) begin
            if (pushes) begin
                for (int i = DEPTH - 1; i > 0; i--) nxt[i] = s[i-1];
                nxt[0] = pv;
                nc     = count + CW'(1);
            end else if (op == OP_POP) begin
                for (int i = 0; i < DEPTH - 1; i++) nxt[i] = s[i+1];
                nxt[DEPTH-1] = '0;
                nc           = count - CW'(1);
            end else if (op == OP_SWAP) begin
                nxt[0] = s[1];
                nxt[1] = s[0];
            end else if (op == OP_REPL) begin
                nxt[0] = d;
            end else if (need3) begin
                nxt[0] = s[2];
                nxt[1] = s[0];
                nxt[2] = s[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) s[i] <= '0;
            count <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            err   <= 1'b0;
        end else begin
            s     <= nxt;
            count <= nc;
            empty <= nc == '0;
            full  <= nc == CW'(DEPTH);
            ovf   <= ovf_c;
            unf   <= unf_c;
            err   <= err | ovf_c | unf_c;
        end
    end

    assign top    = s[0];
    assign second = s[1];
endmodule

// File: tb/tb_word_stack_shiftreg.sv
// tb_word_stack_shiftreg: directed checks of the default WIDTH=4, DEPTH=8 stack.
module tb_word_stack_shiftreg;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic [2:0] op = 3'd0;
    logic [3:0] d = 4'd0, top, second, count;
    logic       empty, full, ovf, unf, err;
    int         checks = 0, errors = 0;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                           SWAP = 3'd4, OVER = 3'd5, REPL = 3'd6, ROT = 3'd7;

    word_stack_shiftreg dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .top(top), .second(second),
        .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic [2:0] o, input logic [3:0] v);
        @(negedge clk);
        rst = r;
        en  = e;
        op  = o;
        d   = v;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(1, 0, NOP, 0);
        chk("rst_top", top, 0);
        chk("rst_second", second, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_flags", {ovf, unf, err}, 0);
        // push 1,2,3 then pop them all
        for (int i = 1; i <= 3; i++) step(0, 1, PUSH, 4'(i));
        chk("t1_top", top, 3);
        chk("t1_second", second, 2);
        chk("t1_count", count, 3);
        chk("t1_empty", empty, 0);
        step(0, 1, POP, 0);
        chk("t1_pop_top", top, 2);
        step(0, 1, POP, 0);
        step(0, 1, POP, 0);
        chk("t1_count0", count, 0);
        chk("t1_empty1", empty, 1);
        chk("t1_top0", top, 0);
        chk("t1_noerr", err, 0);
        // fill to full then overflow
        for (int i = 1; i <= 8; i++) step(0, 1, PUSH, 4'(i));
        chk("t2_full", full, 1);
        chk("t2_count8", count, 8);
        chk("t2_second", second, 7);
        step(0, 1, PUSH, 9);
        chk("t2_ovf", ovf, 1);
        chk("t2_unf", unf, 0);
        chk("t2_err", err, 1);
        chk("t2_top", top, 8);
        chk("t2_count", count, 8);
        step(0, 0, PUSH, 9);
        chk("t2_ovf_drop", ovf, 0);
        chk("t2_err_hold", err, 1);
        chk("t2_hold_count", count, 8);
        step(0, 1, DUP, 0);
        chk("t2_dup_ovf", ovf, 1);
        for (int i = 0; i < 8; i++) step(0, 1, POP, 0);
        chk("t2_drain_count", count, 0);
        chk("t2_drain_top", top, 0);
        chk("t2_drain_flags", {ovf, unf}, 0);
        // underflow cases
        step(0, 1, POP, 0);
        chk("t3_pop_unf", {ovf, unf}, 2'b01);
        step(0, 1, REPL, 5);
        chk("t3_repl_unf", unf, 1);
        chk("t3_repl_top", top, 0);
        step(0, 1, DUP, 0);
        chk("t3_dup_unf", unf, 1);
        step(0, 1, PUSH, 6);
        chk("t3_push_unf0", unf, 0);
        step(0, 1, SWAP, 0);
        chk("t3_swap_unf", unf, 1);
        chk("t3_swap_top", top, 6);
        chk("t3_swap_second", second, 0);
        chk("t3_swap_count", count, 1);
        step(0, 1, OVER, 0);
        chk("t3_over_unf", unf, 1);
        chk("t3_err", err, 1);
        step(0, 1, REPL, 5);
        chk("t3_repl_ok", top, 5);
        chk("t3_repl_cnt", count, 1);
        // swap/over/dup on (7,4)
        step(1, 0, NOP, 0);
        chk("t4_err_clr", err, 0);
        step(0, 1, PUSH, 4);
        step(0, 1, PUSH, 7);
        step(0, 1, SWAP, 0);
        chk("t4_swap_top", top, 4);
        chk("t4_swap_second", second, 7);
        step(0, 1, OVER, 0);
        chk("t4_over_top", top, 7);
        chk("t4_over_second", second, 4);
        chk("t4_over_count", count, 3);
        step(0, 1, DUP, 0);
        chk("t4_dup_top", top, 7);
        chk("t4_dup_second", second, 7);
        chk("t4_dup_count", count, 4);
        chk("t4_noerr", err, 0);
        // opcode 111 on (3,2,1)
        step(1, 0, NOP, 0);
        for (int i = 1; i <= 3; i++) step(0, 1, PUSH, 4'(i));
        step(0, 1, ROT, 0);
        chk("t5_count", count, 3);
        chk("t5_flags", {ovf, unf, err}, 0);
`ifdef WSTACK_ROT_EN
        chk("t5_rot_top", top, 1);
        chk("t5_rot_second", second, 3);
        step(0, 1, POP, 0);
        step(0, 1, POP, 0);
        chk("t5_rot_third", top, 2);
        step(0, 1, ROT, 0);
        chk("t5_rot_unf", unf, 1);
`else
        chk("t5_nop_top", top, 3);
        chk("t5_nop_second", second, 2);
        step(0, 1, POP, 0);
        step(0, 1, POP, 0);
        chk("t5_nop_third", top, 1);
        step(0, 1, ROT, 0);
        chk("t5_nop_unf", {unf, err}, 0);
`endif
        // reset beats en; en=0 holds
        step(1, 0, NOP, 0);
        step(0, 1, POP, 0);
        step(0, 1, PUSH, 5);
        chk("t6_pre_err", err, 1);
        step(1, 1, PUSH, 9);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_top", top, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_empty", empty, 1);
        step(0, 0, PUSH, 9);
        chk("t6_hold_count", count, 0);
        chk("t6_hold_top", top, 0);
        step(0, 1, PUSH, 3);
        step(0, 0, POP, 0);
        chk("t6_hold2_top", top, 3);
        chk("t6_hold2_count", count, 1);
        chk("t6_hold2_flags", {ovf, unf, err}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
